// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the indicator and buzzer sharing logic:
// the arbiter state encoding, default timing constants and a counter-width helper.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FREE = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

    localparam int HOLD_TICKS_DEF = 50;
    localparam int GAP_TICKS_DEF  = 10;

    // Width for a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection among a request vector.
// Fixed priority (lowest set index wins) or round-robin starting at 'start'
// and wrapping modulo N_REQ. Shared by the LED and buzzer arbiters.
module arb_pick #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   start,
    input  logic             rr_en,
    output logic [IDW-1:0]   winner,
    output logic             valid
);

    logic [IDW-1:0] idx;

    // Scan candidates in search order and keep the first one that requests.
    always_comb begin
        // NOTE: every output gets a value before the loop so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'(rr_en ? (int'(start) + k) % N_REQ : k);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/indicator_arbiter.sv
// Shares one status LED among N_REQ indicator sources. A granted owner keeps
// the LED for at least HOLD_TICKS cycles; handovers insert GAP_TICKS dark cycles.
// Build option: define INDICATOR_ARB_RR_EN for round-robin selection where any
// other pending request preempts a FREE owner; otherwise fixed priority (index 0 first).
module indicator_arbiter
    import fan_ctrl_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int HOLD_TICKS = HOLD_TICKS_DEF,
    parameter  int GAP_TICKS  = GAP_TICKS_DEF,
    localparam int IDW        = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] led_in,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   owner_id,
    output logic             busy,
    output logic             led
);

    localparam int HW     = cnt_width(HOLD_TICKS + 1);
    localparam int GW     = cnt_width(GAP_TICKS + 1);
    localparam bit NO_GAP = (GAP_TICKS == 0);

`ifdef INDICATOR_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_e       state;
    logic [HW-1:0]    hold_cnt;
    logic [GW-1:0]    gap_cnt;

    logic [N_REQ-1:0] owner_mask;
    logic             owner_req;
    logic             preempt;
    logic             release_now;
    logic             arb_now;
    logic [IDW-1:0]   pick_start;
    logic [IDW-1:0]   pick_id;
    logic             pick_valid;

    arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .start  (pick_start),
        .rr_en  (RR_EN),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    // Decide whether the owner lets go this cycle and whether arbitration runs.
    always_comb begin
        owner_mask = N_REQ'(1) << owner_id;
        owner_req  = |(req & owner_mask);
`ifdef INDICATOR_ARB_RR_EN
        preempt    = |(req & ~owner_mask);
`else
        preempt    = |(req & (owner_mask - 1'b1));
`endif
        release_now = ((state == ST_HOLD) && !owner_req) ||
                      ((state == ST_FREE) && (!owner_req || preempt));
        // With no dark gap a release arbitrates on the same edge.
        arb_now     = (state == ST_IDLE) ||
                      ((state == ST_GAP) && (gap_cnt == '0)) ||
                      (release_now && NO_GAP);
        pick_start  = (owner_id == IDW'(N_REQ - 1)) ? '0 : owner_id + 1'b1;
    end

    // Arbiter FSM with both counters and all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            gnt      <= '0;
            owner_id <= '0;
            busy     <= 1'b0;
            led      <= 1'b0;
        end else if (arb_now) begin
            // NOTE: non-blocking assignments so every register updates from the
            // values present before this edge, regardless of statement order.
            if (pick_valid) begin
                state    <= ST_HOLD;
                hold_cnt <= HW'(HOLD_TICKS - 1);
                gnt      <= N_REQ'(1) << pick_id;
                owner_id <= pick_id;
                busy     <= 1'b1;
                led      <= led_in[pick_id];
            end else begin
                state <= ST_IDLE;
                gnt   <= '0;
                busy  <= 1'b0;
                led   <= 1'b0;
            end
        end else if (release_now) begin
            state   <= ST_GAP;
            gap_cnt <= GW'(NO_GAP ? 0 : GAP_TICKS - 1);
            gnt     <= '0;
            busy    <= 1'b0;
            led     <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    led <= led_in[owner_id];
                    if (hold_cnt == '0) begin
                        state <= ST_FREE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_FREE: begin
                    led <= led_in[owner_id];
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
